// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file slave.
package spi_regfile_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  localparam int CMD_W       = 8;
  localparam int CMD_WR_BIT  = 7;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with one-clk rise/fall pulses.
module spi_sync_edge
  import spi_regfile_pkg::*;
#(
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE_VAL}};
      prev_q <= IDLE_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;
endmodule

// File: rtl/spi_regfile_slave.sv
// SPI mode-0 slave owning a NUM_REGS x DATA_W register file, oversampled on clk.
// Define SPI_AUTOINC_EN to advance the address after every data word (burst access).
module spi_regfile_slave
  import spi_regfile_pkg::*;
#(
  parameter int                          DATA_W     = 8,
  parameter int                          NUM_REGS   = 4,
  parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VALS = {8'h03, 8'h02, 8'h01, 8'h96},
  localparam int                         ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         mosi,
  input  logic                         cs_n,
  output logic                         miso,
  output logic                         miso_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         busy
);
  localparam int RX_W  = (DATA_W > CMD_W) ? DATA_W : CMD_W;
  localparam int CNT_W = $clog2(RX_W);
  localparam int AW    = CMD_W - 1;

  logic sclk_rise, sclk_fall, unused_sclk_lvl;
  logic cs_lvl, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;

  spi_sync_edge #(.IDLE_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d_i(sclk),
    .level_o(unused_sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.IDLE_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .d_i(cs_n),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_q <= '0;
    else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  state_e                           state_q, state_d;
  logic [CNT_W-1:0]                 bitcnt_q, bitcnt_d;
  logic [RX_W-2:0]                  rx_q, rx_d;
  logic [RX_W-1:0]                  rx_nxt;
  logic [AW-1:0]                    addr_q, addr_d;
  logic                             wr_q, wr_d;
  logic [DATA_W-1:0]                tx_q, tx_d;
  logic                             skip_q, skip_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
  logic                             wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]                wr_addr_q, wr_addr_d;

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  // Out-of-range addresses are sticky so a burst never lands in valid space.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    if (!in_range(a)) return a;
`ifdef SPI_AUTOINC_EN
    return (int'(a) == NUM_REGS - 1) ? '0 : a + AW'(1);
`else
    return a;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] rd_word(input logic [AW-1:0] a);
    return in_range(a) ? regs_q[a[ADDR_W-1:0]] : '0;
  endfunction

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    rx_d        = rx_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    tx_d        = tx_q;
    skip_d      = skip_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    rx_nxt      = {rx_q, mosi_s};
    unique case (state_q)
      IDLE: if (cs_fall) begin
        state_d  = CMD;
        bitcnt_d = '0;
        rx_d     = '0;
        tx_d     = '0;
        skip_d   = 1'b0;
      end
      CMD, DATA: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else begin
          // A freshly loaded word must survive the falling edge that precedes its first bit.
          if (sclk_fall) begin
            if (skip_q) skip_d = 1'b0;
            else        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
          if (sclk_rise) begin
            rx_d     = rx_nxt[RX_W-2:0];
            bitcnt_d = bitcnt_q + CNT_W'(1);
            if (state_q == CMD && bitcnt_q == CNT_W'(CMD_W - 1)) begin
              state_d  = DATA;
              bitcnt_d = '0;
              wr_d     = rx_nxt[CMD_WR_BIT];
              addr_d   = rx_nxt[AW-1:0];
              tx_d     = rd_word(rx_nxt[AW-1:0]);
              skip_d   = 1'b1;
            end else if (state_q == DATA && bitcnt_q == CNT_W'(DATA_W - 1)) begin
              bitcnt_d = '0;
              if (wr_q && in_range(addr_q)) begin
                regs_d[addr_q[ADDR_W-1:0]] = rx_nxt[DATA_W-1:0];
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q[ADDR_W-1:0];
              end
              addr_d = next_addr(addr_q);
              tx_d   = rd_word(next_addr(addr_q));
              skip_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      rx_q        <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      tx_q        <= '0;
      skip_q      <= 1'b0;
      regs_q      <= RESET_VALS;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_q        <= rx_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      tx_q        <= tx_d;
      skip_q      <= skip_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign miso_oe   = ~cs_lvl;
  assign miso      = miso_oe & tx_q[DATA_W-1];
  assign regs_flat = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: doc/spi_regfile_slave.md
Name: spi_regfile_slave

Overview:
- Parametrised SPI slave (mode 0, MSB first) that owns a register file of NUM_REGS x DATA_W bits.
- Runs entirely on the system clock and oversamples sclk/mosi/cs_n through synchronisers.
- Adds features the fixed 4x8 generation lacks: read/write command bit, burst auto-increment, out-of-range protection, and a write strobe for downstream consumers such as the PWM channels.
- Sits between the ui_in SPI pins and the PWM/config logic, which reads regs_flat directly.

Parameters:
- DATA_W, 8: register and data-phase width in bits.
- NUM_REGS, 4: number of registers, 2..128.
- RESET_VALS, {8'h03,8'h02,8'h01,8'h96}: packed reset values, NUM_REGS*DATA_W bits, reg0 in the LSBs.
- ADDR_W, $clog2(NUM_REGS): localparam, not overridable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock, asynchronous to clk.
- mosi  in  1  SPI data in, asynchronous.
- cs_n  in  1  SPI chip select, active low, asynchronous.
- miso  out  1  SPI data out.
- miso_oe  out  1  high while a frame is selected (synchronised cs_n low).
- regs_flat  out  NUM_REGS*DATA_W  all registers, reg0 in the LSBs.
- wr_strobe  out  1  one-clk pulse when a register is written.
- wr_addr  out  ADDR_W  address of the last write, valid with wr_strobe.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: regs = RESET_VALS; miso=0, miso_oe=0, wr_strobe=0, wr_addr=0, busy=0; state=IDLE; shift registers and counters cleared; all synchroniser flops set to idle levels (sclk=0, cs_n=1, mosi=0).
- Synchronisation: 2-flop synchroniser on each input, plus one edge-detect flop on sclk and cs_n.
  - Pin edge to internal event latency is 3 clk.
  - sclk high and low phases must each be at least 4 clk.
- States:
  - IDLE: wait for cs_n falling edge, then go to CMD with bit count 0.
  - CMD: capture 8 bits on sclk rising edges. cmd[7]=1 means write, 0 means read. cmd[6:0] is the start address. After bit 8, go to DATA.
  - DATA: capture DATA_W bits, then perform the access, advance the address and restart the bit count.
  - Any state: cs_n rising edge returns to IDLE on the same edge-detect cycle.
- Read path:
  - On CMD completion, load the tx shifter with reg[addr], or 0 if addr >= NUM_REGS.
  - miso drives tx MSB.
  - Shift on each sclk falling edge.
  - Reload with the next address after every DATA_W bits.
  - miso = 0 whenever miso_oe = 0.
- Write path:
  - The cycle after the DATA_W-th rising edge: reg[addr] <= rx data, wr_strobe=1, wr_addr=addr.
  - Writes with addr >= NUM_REGS are dropped with no strobe.
  - Write frames also drive miso with the old register value (full duplex).
- Address advance: addr+1, wrapping NUM_REGS-1 -> 0 (behaviour depends on the optional feature below).
- Out-of-range starting address: stays out of range and never wraps into valid space.
- cs_n deasserted mid-command or mid-data: partial bits are discarded, no write, no strobe.
- Simultaneous sclk edge and cs_n rise in the same cycle: cs_n wins and the edge is ignored.
- Extra sclk edges while in IDLE are ignored.
- rst_n asserted mid-frame: immediate return to reset state; the frame resumes only after a fresh cs_n fall.

Optional Feature:
- Macro: SPI_AUTOINC_EN.
- Defined: addr advances after each DATA_W word (burst access) with wrap as above.
- Undefined: addr is held, so every data word in the frame accesses the starting register; a burst write keeps the last word, and each word strobes.

Decomposition:
- Package spi_regfile_pkg holds:
  - State enum: IDLE, CMD, DATA.
  - CMD_W=8 and CMD_WR_BIT=7.
  - SYNC_STAGES=2.
- One sub-module, spi_sync_edge: synchroniser with rise/fall pulses, instantiated for sclk and cs_n, with a plain 2-flop for mosi.
- Shifters, FSM and register file stay in the top.

Test Plan:
- Reset then read: cmd 0x00, 8 clocks -> miso returns 0x96; regs_flat = 0x03020196; busy=0 after cs_n high.
- Single write: cmd 0x81, data 0xA5 -> reg1=0xA5; one wr_strobe pulse with wr_addr=1; the following read of 0x01 returns 0xA5.
- Burst with wrap (SPI_AUTOINC_EN): cmd 0x83, data 0x11, 0x22 -> reg3=0x11, reg0=0x22, two strobes with wr_addr 3 then 0. Without the macro: reg3=0x22, reg0 unchanged.
- Abort: cmd 0x82 then 4 data bits, cs_n high -> reg2 stays 0x02, no strobe, state IDLE within 3 clk.
- Out of range (NUM_REGS=4): cmd 0x85 with data 0xFF -> no register changes, no strobe. Read cmd 0x05 -> miso all zeros.
- Reset mid-frame: assert rst_n low during the data phase of a 0x80 write -> regs back to RESET_VALS, miso_oe=0. A new frame after release works normally.
